// File: rtl/add_rs_param.sv
// add_rs_param: parametrised add/sub reservation station with CDB snoop, age-ordered issue and ICC result broadcast.
// Optional dispatch-cycle CDB capture is enabled by defining ADD_RS_DISPATCH_BYPASS_EN.
module add_rs_param #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 5,
    parameter int DEPTH    = 4,
    parameter int BASE_TAG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_rs_enable,
    input  logic [5:0]        in_operator_type,
    input  logic [DATA_W-1:0] in_val_1,
    input  logic [DATA_W-1:0] in_val_2,
    input  logic [TAG_W-1:0]  in_tag_1,
    input  logic [TAG_W-1:0]  in_tag_2,
    input  logic              in_icc_c,
    output logic              out_rs_ready,
    output logic [TAG_W-1:0]  out_rs_tag,
    input  logic              in_CDB_broadcast,
    input  logic [TAG_W-1:0]  in_CDB_tag,
    input  logic [DATA_W-1:0] in_CDB_val,
    output logic              out_CDB_req,
    input  logic              in_CDB_grant,
    output logic [TAG_W-1:0]  out_CDB_tag,
    output logic [DATA_W-1:0] out_CDB_val,
    output logic [3:0]        out_ICC_flags,
    output logic              out_icc_valid
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] INV = '1;
    typedef enum logic [2:0] {FREE, WAIT, READY, EXEC, DONE} st_t;

    st_t               r_st   [DEPTH];
    logic [TAG_W-1:0]  r_tag1 [DEPTH];
    logic [TAG_W-1:0]  r_tag2 [DEPTH];
    logic [DATA_W-1:0] r_v1   [DEPTH];
    logic [DATA_W-1:0] r_v2   [DEPTH];
    logic [DATA_W-1:0] r_res  [DEPTH];
    logic [3:0]        r_flg  [DEPTH];
    logic              r_sub  [DEPTH];
    logic              r_x    [DEPTH];
    logic              r_cc   [DEPTH];
    logic              r_cin  [DEPTH];
    // r_age[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0]  r_age  [DEPTH];
    logic              r_lock;
    logic [IW-1:0]     r_lock_idx;

    logic              w_free_any, w_rdy_any, w_done_any, w_accept, w_rdy_old, w_done_old;
    logic [IW-1:0]     w_free_idx, w_rdy_idx, w_done_idx, w_exec_idx, w_sel;
    logic [TAG_W-1:0]  w_t1, w_t2;
    logic [DATA_W-1:0] w_d1, w_d2, w_a, w_b, w_res;
    logic [DATA_W:0]   w_sum;
    logic              w_ci, w_c, w_v;
    logic              w_hit1 [DEPTH];
    logic              w_hit2 [DEPTH];

    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_rdy_any  = 1'b0;
        w_rdy_idx  = '0;
        w_done_any = 1'b0;
        w_done_idx = '0;
        w_exec_idx = '0;
        w_rdy_old  = 1'b0;
        w_done_old = 1'b0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (r_st[i] == FREE) begin
                w_free_any = 1'b1;
                w_free_idx = IW'(i);
            end
        for (int i = 0; i < DEPTH; i++) begin
            w_rdy_old  = r_st[i] == READY;
            w_done_old = r_st[i] == DONE;
            for (int j = 0; j < DEPTH; j++) begin
                if (r_st[j] == READY && r_age[j][i]) w_rdy_old = 1'b0;
                if (r_st[j] == DONE && r_age[j][i]) w_done_old = 1'b0;
            end
            if (w_rdy_old) begin
                w_rdy_any = 1'b1;
                w_rdy_idx = IW'(i);
            end
            if (w_done_old) begin
                w_done_any = 1'b1;
                w_done_idx = IW'(i);
            end
            if (r_st[i] == EXEC) w_exec_idx = IW'(i);
            w_hit1[i] = r_st[i] == WAIT && in_CDB_broadcast && r_tag1[i] != INV && r_tag1[i] == in_CDB_tag;
            w_hit2[i] = r_st[i] == WAIT && in_CDB_broadcast && r_tag2[i] != INV && r_tag2[i] == in_CDB_tag;
        end
    end

`ifdef ADD_RS_DISPATCH_BYPASS_EN
    assign w_t1 = (in_CDB_broadcast && in_tag_1 != INV && in_tag_1 == in_CDB_tag) ? INV : in_tag_1;
    assign w_t2 = (in_CDB_broadcast && in_tag_2 != INV && in_tag_2 == in_CDB_tag) ? INV : in_tag_2;
    assign w_d1 = (in_tag_1 != w_t1) ? in_CDB_val : in_val_1;
    assign w_d2 = (in_tag_2 != w_t2) ? in_CDB_val : in_val_2;
`else
    assign w_t1 = in_tag_1;
    assign w_t2 = in_tag_2;
    assign w_d1 = in_val_1;
    assign w_d2 = in_val_2;
`endif

    assign w_accept = in_rs_enable && w_free_any && !in_operator_type[5] && in_operator_type[1:0] == 2'b00;
    assign w_a      = r_v1[w_exec_idx];
    assign w_b      = r_v2[w_exec_idx];
    assign w_ci     = r_x[w_exec_idx] & r_cin[w_exec_idx];
    // the extra top bit is carry for ADD and borrow for SUB
    assign w_sum    = r_sub[w_exec_idx] ? {1'b0, w_a} - {1'b0, w_b} - (DATA_W+1)'(w_ci)
                                        : {1'b0, w_a} + {1'b0, w_b} + (DATA_W+1)'(w_ci);
    assign w_res    = w_sum[DATA_W-1:0];
    assign w_c      = w_sum[DATA_W];
    assign w_v      = r_sub[w_exec_idx] ? (w_a[DATA_W-1] != w_b[DATA_W-1]) && (w_res[DATA_W-1] != w_a[DATA_W-1])
                                        : (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_res[DATA_W-1] != w_a[DATA_W-1]);

    // once presented without a grant, the chosen entry stays on the bus even if an older one completes
    assign w_sel         = r_lock ? r_lock_idx : w_done_idx;
    assign out_CDB_req   = w_done_any;
    assign out_CDB_tag   = w_done_any ? TAG_W'(BASE_TAG) + TAG_W'(w_sel) : INV;
    assign out_CDB_val   = w_done_any ? r_res[w_sel] : '0;
    assign out_ICC_flags = w_done_any ? r_flg[w_sel] : 4'd0;
    assign out_icc_valid = w_done_any && r_cc[w_sel];
    assign out_rs_ready  = w_free_any;
    assign out_rs_tag    = TAG_W'(BASE_TAG) + TAG_W'(w_free_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_st[i]  <= FREE;
                r_age[i] <= '0;
            end
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                case (r_st[i])
                    FREE:    if (w_accept && w_free_idx == IW'(i)) r_st[i] <= (w_t1 == INV && w_t2 == INV) ? READY : WAIT;
                    WAIT:    if ((w_hit1[i] || r_tag1[i] == INV) && (w_hit2[i] || r_tag2[i] == INV)) r_st[i] <= READY;
                    READY:   if (w_rdy_any && w_rdy_idx == IW'(i)) r_st[i] <= EXEC;
                    EXEC:    r_st[i] <= DONE;
                    DONE:    if (in_CDB_grant && w_sel == IW'(i)) r_st[i] <= FREE;
                    default: r_st[i] <= FREE;
                endcase
            if (w_accept) begin
                for (int j = 0; j < DEPTH; j++) r_age[j][w_free_idx] <= 1'b1;
                r_age[w_free_idx] <= '0;
            end
            r_lock     <= w_done_any && !in_CDB_grant;
            r_lock_idx <= w_sel;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (r_st[i] == FREE && w_accept && w_free_idx == IW'(i)) begin
                r_tag1[i] <= w_t1;
                r_tag2[i] <= w_t2;
                r_v1[i]   <= w_d1;
                r_v2[i]   <= w_d2;
                r_sub[i]  <= in_operator_type[2];
                r_x[i]    <= in_operator_type[3];
                r_cc[i]   <= in_operator_type[4];
                r_cin[i]  <= in_icc_c;
            end else begin
                if (w_hit1[i]) begin
                    r_tag1[i] <= INV;
                    r_v1[i]   <= in_CDB_val;
                end
                if (w_hit2[i]) begin
                    r_tag2[i] <= INV;
                    r_v2[i]   <= in_CDB_val;
                end
            end
            if (r_st[i] == EXEC) begin
                r_res[i] <= w_res;
                r_flg[i] <= {w_c, w_v, w_res == '0, w_res[DATA_W-1]};
            end
        end
    end
endmodule

// File: tb/tb_add_rs_param.sv
// tb_add_rs_param: directed-vector bench for add_rs_param with default parameters.
module tb_add_rs_param;
    localparam logic [4:0] INV = 5'h1f;
    localparam logic [5:0] ADD = 6'b000000, ADDCC = 6'b010000, ADDX = 6'b001000,
                           SUBCC = 6'b010100, SUBX = 6'b001100;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        en = 1'b0, icc_c = 1'b0, bc = 1'b0, grant = 1'b0;
    logic [5:0]  opc = '0;
    logic [31:0] val1 = '0, val2 = '0, bc_val = '0;
    logic [4:0]  tag1 = INV, tag2 = INV, bc_tag = '0;
    logic        rs_ready, req, icc_v;
    logic [4:0]  rs_tag, cdb_tag;
    logic [31:0] cdb_val;
    logic [3:0]  flags;
    int          errs = 0, checks = 0;

    always #5 clk = ~clk;

    add_rs_param dut (
        .clk(clk), .rst_n(rst_n), .in_rs_enable(en), .in_operator_type(opc),
        .in_val_1(val1), .in_val_2(val2), .in_tag_1(tag1), .in_tag_2(tag2), .in_icc_c(icc_c),
        .out_rs_ready(rs_ready), .out_rs_tag(rs_tag),
        .in_CDB_broadcast(bc), .in_CDB_tag(bc_tag), .in_CDB_val(bc_val),
        .out_CDB_req(req), .in_CDB_grant(grant), .out_CDB_tag(cdb_tag), .out_CDB_val(cdb_val),
        .out_ICC_flags(flags), .out_icc_valid(icc_v)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t1, input logic [4:0] t2, input logic c);
        en = 1'b1; opc = op; val1 = a; val2 = b; tag1 = t1; tag2 = t2; icc_c = c;
        tick;
        en = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [31:0] ev, input logic [3:0] ef, input logic ei);
        grant = 1'b1;
        disp(op, a, b, INV, INV, c);
        tick;
        check({nm, "_req_early"}, req, 0);
        tick;
        check({nm, "_req"}, req, 1);
        check({nm, "_tag"}, cdb_tag, 0);
        check({nm, "_val"}, cdb_val, ev);
        check({nm, "_flags"}, flags, ef);
        check({nm, "_iccv"}, icc_v, ei);
        tick;
        check({nm, "_freed"}, req, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_req", req, 0);
        check("rst_tag", cdb_tag, INV);
        check("rst_val", cdb_val, 0);
        check("rst_flags", flags, 0);
        check("rst_iccv", icc_v, 0);
        check("rst_ready", rs_ready, 1);
        check("rst_rstag", rs_tag, 0);
        rst_n = 1'b1;
        tick;

        run_op("add", ADD, 5, 7, 0, 12, 4'b0000, 0);
        run_op("subcc", SUBCC, 32'h0, 32'h1, 0, 32'hffffffff, 4'b1001, 1);
        run_op("addcc_ovf", ADDCC, 32'h7fffffff, 32'h1, 0, 32'h80000000, 4'b0101, 1);
        run_op("addcc_zero", ADDCC, 32'hffffffff, 32'h1, 0, 32'h0, 4'b1010, 1);
        run_op("addx", ADDX, 3, 4, 1, 8, 4'b0000, 0);
        run_op("subx", SUBX, 10, 3, 1, 6, 4'b0000, 0);
        run_op("add_nocin", ADD, 3, 4, 1, 7, 4'b0000, 0);

        disp(6'b100000, 1, 1, INV, INV, 0);
        check("illegal_rstag", rs_tag, 0);
        tick; tick;
        check("illegal_noreq", req, 0);

        disp(ADD, 0, 0, 9, 9, 0);
        check("wait_rstag", rs_tag, 1);
        tick; tick; tick;
        check("wait_noreq", req, 0);
        bc = 1'b1; bc_tag = 9; bc_val = 20;
        tick;
        bc = 1'b0;
        tick;
        check("snoop_req_early", req, 0);
        tick;
        check("snoop_req", req, 1);
        check("snoop_val", cdb_val, 40);
        tick;
        check("snoop_freed", req, 0);

        grant = 1'b0;
        for (int k = 1; k <= 4; k++) disp(ADD, k, k, INV, INV, 0);
        check("full_ready", rs_ready, 0);
        disp(ADD, 9, 9, INV, INV, 0);
        tick; tick;
        check("full_ready2", rs_ready, 0);
        check("full_tag", cdb_tag, 0);
        check("full_val", cdb_val, 2);
        tick;
        check("hold_tag", cdb_tag, 0);
        grant = 1'b1;
        tick;
        grant = 1'b0;
        check("grant_ready", rs_ready, 1);
        check("grant_rstag", rs_tag, 0);
        check("grant_next_tag", cdb_tag, 1);
        disp(ADD, 100, 1, INV, INV, 0);
        tick; tick;
        begin
            logic [4:0]  etag [4] = '{1, 2, 3, 0};
            logic [31:0] eval [4] = '{4, 6, 8, 101};
            for (int k = 0; k < 4; k++) begin
                check("age_tag", cdb_tag, etag[k]);
                check("age_val", cdb_val, eval[k]);
                grant = 1'b1;
                tick;
            end
        end
        grant = 1'b0;
        check("age_empty", req, 0);

        disp(ADD, 1, 2, INV, INV, 0);
        disp(ADD, 3, 4, INV, INV, 0);
        tick; tick; tick;
        check("pre_rst_req", req, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", req, 0);
        check("mid_rst_tag", cdb_tag, INV);
        check("mid_rst_val", cdb_val, 0);
        check("mid_rst_ready", rs_ready, 1);
        #2;
        rst_n = 1'b1;
        grant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("post_rst_noreq", req, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
